lvds_rx_framer: RTL and testbench

//  Parametrised successor to the modem LVDS receive deserialiser.
//  - Captures LANE_W bits per i_ddr_clk from the modem LVDS lane.
//  - Frames I/Q halves on the I-sync / Q-sync symbols and pushes one complete frame word to the RX FIFO.
//  - Adds enable gating, lock qualification, per-frame sync-input tagging, and saturating frame-error / overflow counters.
//  - Sits between the LVDS input pads/DDR capture and the async RX FIFO feeding the SPI/SMI side.

---
 rtl/lvds_rx_pkg.sv | 21 ++
 rtl/lvds_rx_framer_sat_counter.sv | 30 +++
 rtl/lvds_rx_framer.sv | 182 ++++++++++++++++++
 tb/tb_lvds_rx_framer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg
//   Shared definitions for the LVDS receive framer.
//   - FSM state encodings (also the o_debug_state values)
//   - default I/Q sync symbols for a 2-bit lane
//   - frame word width derivation
package lvds_rx_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_I_PHASE = 2'd1;
  localparam logic [1:0] ST_Q_SYNC  = 2'd2;
  localparam logic [1:0] ST_Q_PHASE = 2'd3;

  localparam logic [1:0] DEF_I_SYNC = 2'b10;
  localparam logic [1:0] DEF_Q_SYNC = 2'b01;

  // One frame = I half + Q half, each half_syms symbols of lane_w bits.
  function automatic int word_w(input int lane_w, input int half_syms);
    return 2 * half_syms * lane_w;
  endfunction

endpackage

// File: rtl/lvds_rx_framer_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     i_ddr_clk  clock
//     i_rst      synchronous active-high reset
//     i_inc      count up by one (sticks at all-ones)
//     i_clr      clear to zero; wins over a same-edge i_inc
//     o_cnt      current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_ddr_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst || i_clr)
      cnt_q <= '0;
    else if (i_inc && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/lvds_rx_framer.sv
// lvds_rx_framer
//   Deserialises the modem LVDS lane into I/Q frame words for the RX FIFO.
//   A frame is HALF_SYMS symbols of I (led by I_SYNC) followed by HALF_SYMS
//   symbols of Q (led by Q_SYNC). Completed frames are pushed to the FIFO,
//   qualified by lock and FIFO space; Q-sync misses and dropped frames are
//   counted.
//   Ports:
//     i_ddr_clk         lane clock, everything on its rising edge
//     i_rst             synchronous active-high reset
//     i_ddr_data        received lane symbol
//     i_enable          low holds the FSM idle and drops any partial frame
//     i_sync_input      external sync marker, tagged onto each frame
//     i_cnt_clear       clears both status counters
//     i_fifo_full       RX FIFO full
//     o_fifo_write_clk  FIFO write clock (= i_ddr_clk)
//     o_fifo_push       one-cycle write strobe
//     o_fifo_data       frame word, first symbol in the MSBs
//     o_fifo_sync       i_sync_input captured at this frame's I-sync
//     o_locked          LOCK_FRAMES consecutive good frames seen
//     o_frame_err_cnt   Q-sync mismatches (saturating)
//     o_overflow_cnt    good frames dropped because the FIFO was full
//     o_debug_state     FSM state
module lvds_rx_framer
  import lvds_rx_pkg::*;
#(
  parameter int                LANE_W       = 2,
  parameter int                HALF_SYMS    = 8,
  parameter logic [LANE_W-1:0] I_SYNC       = LANE_W'(DEF_I_SYNC),
  parameter logic [LANE_W-1:0] Q_SYNC       = LANE_W'(DEF_Q_SYNC),
  parameter int                LOCK_FRAMES  = 4,
  parameter int                REQUIRE_LOCK = 1,
  parameter int                CNT_W        = 16,
  localparam int               WORD_W       = word_w(LANE_W, HALF_SYMS)
) (
  input  logic              i_ddr_clk,
  input  logic              i_rst,
  input  logic [LANE_W-1:0] i_ddr_data,
  input  logic              i_enable,
  input  logic              i_sync_input,
  input  logic              i_cnt_clear,
  input  logic              i_fifo_full,
  output logic              o_fifo_write_clk,
  output logic              o_fifo_push,
  output logic [WORD_W-1:0] o_fifo_data,
  output logic              o_fifo_sync,
  output logic              o_locked,
  output logic [CNT_W-1:0]  o_frame_err_cnt,
  output logic [CNT_W-1:0]  o_overflow_cnt,
  output logic [1:0]        o_debug_state
);

  localparam int CW = (HALF_SYMS > 2) ? $clog2(HALF_SYMS) : 1;
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam int SR_W = WORD_W - LANE_W;

  logic [LANE_W-1:0] sym_q;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  // Holds the previous WORD_W/LANE_W-1 symbols; the current sym_q
  // completes the word, so the top symbol never needs storing.
  logic [SR_W-1:0]   frame_sr;
  logic              sync_lat;
  logic [LW-1:0]     good_cnt;

  logic last_sym;
  logic frame_done;
  logic frame_err;
  logic push_ok;
  logic ovf_inc;

  assign last_sym = (cnt == CW'(HALF_SYMS - 1));
  assign push_ok  = o_locked | (REQUIRE_LOCK == 0);
  assign ovf_inc  = frame_done & i_fifo_full & push_ok;

  always_comb begin
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (i_enable) begin
      case (state)
        ST_Q_SYNC:  frame_err  = (sym_q != Q_SYNC);
        ST_Q_PHASE: frame_done = last_sym;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      sym_q       <= '0;
      state       <= ST_IDLE;
      cnt         <= '0;
      frame_sr    <= '0;
      sync_lat    <= 1'b0;
      good_cnt    <= '0;
      o_locked    <= 1'b0;
      o_fifo_push <= 1'b0;
      o_fifo_data <= '0;
      o_fifo_sync <= 1'b0;
    end else begin
      sym_q       <= i_ddr_data;
      frame_sr    <= {frame_sr[SR_W-LANE_W-1:0], sym_q};
      o_fifo_push <= 1'b0;
      if (!i_enable) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        good_cnt <= '0;
        o_locked <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sym_q == I_SYNC) begin
              state    <= ST_I_PHASE;
              cnt      <= CW'(1);
              sync_lat <= i_sync_input;
            end
          end
          ST_I_PHASE: begin
            if (last_sym) begin
              state <= ST_Q_SYNC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_Q_SYNC: begin
            // A mismatch goes straight to IDLE; the bad symbol is not
            // reconsidered as a new I-sync.
            if (sym_q == Q_SYNC) begin
              state <= ST_Q_PHASE;
              cnt   <= CW'(1);
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            if (last_sym) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase

        if (frame_err) begin
          good_cnt <= '0;
          o_locked <= 1'b0;
        end else if (frame_done) begin
          if (good_cnt != LW'(LOCK_FRAMES))
            good_cnt <= good_cnt + 1'b1;
          // Locked once the saturated count reaches LOCK_FRAMES; push uses
          // the lock state from before this frame.
          o_locked    <= (good_cnt >= LW'(LOCK_FRAMES - 1));
          o_fifo_data <= {frame_sr, sym_q};
          o_fifo_sync <= sync_lat;
          o_fifo_push <= ~i_fifo_full & push_ok;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_ddr_clk (i_ddr_clk),
    .i_rst     (i_rst),
    .i_inc     (frame_err),
    .i_clr     (i_cnt_clear),
    .o_cnt     (o_frame_err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .i_ddr_clk (i_ddr_clk),
    .i_rst     (i_rst),
    .i_inc     (ovf_inc),
    .i_clr     (i_cnt_clear),
    .o_cnt     (o_overflow_cnt)
  );

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_debug_state    = state;

endmodule

// File: tb/tb_lvds_rx_framer.sv
// tb_lvds_rx_framer
//   Directed scenarios plus a random symbol stream, checked every cycle
//   against a symbol-stream reference model, with explicit end-of-scenario
//   checks on top.
module tb_lvds_rx_framer;

  localparam int  HALF  = 8;
  localparam int  NSYM  = 2 * HALF;
  localparam int  LOCKN = 4;
  localparam bit  REQ   = 1'b1;
  localparam logic [1:0] ISY = 2'b10;
  localparam logic [1:0] QSY = 2'b01;
  localparam int  SATV  = 65535;

  logic        clk = 1'b0;
  logic        rst, en, sync_in, clr, full;
  logic [1:0]  d;
  logic        wclk, push, fsync, locked;
  logic [31:0] data;
  logic [15:0] err_cnt, ovf_cnt;
  logic [1:0]  dbg;

  always #5 clk = ~clk;

  lvds_rx_framer #(
    .LANE_W(2), .HALF_SYMS(HALF), .I_SYNC(ISY), .Q_SYNC(QSY),
    .LOCK_FRAMES(LOCKN), .REQUIRE_LOCK(1), .CNT_W(16)
  ) dut (
    .i_ddr_clk(clk), .i_rst(rst), .i_ddr_data(d), .i_enable(en),
    .i_sync_input(sync_in), .i_cnt_clear(clr), .i_fifo_full(full),
    .o_fifo_write_clk(wclk), .o_fifo_push(push), .o_fifo_data(data),
    .o_fifo_sync(fsync), .o_locked(locked), .o_frame_err_cnt(err_cnt),
    .o_overflow_cnt(ovf_cnt), .o_debug_state(dbg)
  );

  int checks = 0, passes = 0, fails = 0, cyc = 0;
  int npush = 0;
  int push_cyc[$];
  logic [7:0] psync = '0;

  // Reference model: tracks where the current frame started in the
  // consumed-symbol stream and its age in symbols.
  logic [1:0]  m_symq;
  bit          m_in;
  int          m_age;
  logic [1:0]  m_sym [NSYM];
  bit          m_lat, m_push, m_sync, m_locked;
  logic [31:0] m_data;
  int          m_good, m_err, m_ovf;

  task automatic model_reset();
    m_symq = '0; m_in = 0; m_age = 0; m_lat = 0; m_push = 0; m_sync = 0;
    m_locked = 0; m_data = '0; m_good = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    logic [1:0] c;
    bit done, ferr, ok;
    c = m_symq; done = 0; ferr = 0;
    if (rst) begin
      model_reset();
    end else begin
      m_symq = d;
      ok = m_locked || !REQ;
      if (!en) begin
        m_in = 0; m_good = 0; m_locked = 0;
      end else if (!m_in) begin
        if (c == ISY) begin
          m_in = 1; m_age = 0; m_sym[0] = c; m_lat = sync_in;
        end
      end else begin
        m_age++;
        m_sym[m_age] = c;
        if (m_age == HALF && c != QSY) begin
          ferr = 1; m_in = 0;
        end else if (m_age == NSYM - 1) begin
          done = 1; m_in = 0;
        end
      end
      m_push = done && !full && ok;
      if (done) begin
        m_data = '0;
        for (int i = 0; i < NSYM; i++) m_data = {m_data[29:0], m_sym[i]};
        m_sync = m_lat;
      end
      if (ferr) begin
        m_good = 0; m_locked = 0;
      end else if (done) begin
        m_good   = (m_good + 1 > LOCKN) ? LOCKN : m_good + 1;
        m_locked = (m_good == LOCKN);
      end
      if (clr) m_err = 0;
      else if (ferr) m_err = (m_err == SATV) ? SATV : m_err + 1;
      if (clr) m_ovf = 0;
      else if (done && full && ok) m_ovf = (m_ovf == SATV) ? SATV : m_ovf + 1;
    end
  endtask

  function automatic logic [31:0] m_state();
    if (!m_in) return 32'd0;
    if (m_age <= HALF - 2) return 32'd1;
    if (m_age == HALF - 1) return 32'd2;
    return 32'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("push",    32'(push),    32'(m_push));
    chk("data",    data,         m_data);
    chk("sync",    32'(fsync),   32'(m_sync));
    chk("locked",  32'(locked),  32'(m_locked));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("state",   32'(dbg),     m_state());
    if (push) begin
      npush++;
      push_cyc.push_back(cyc);
      psync = {psync[6:0], fsync};
    end
  endtask

  task automatic send_sym(input logic [1:0] s);
    d = s;
    step();
  endtask

  // sync_tag holds i_sync_input across the cycle the I-sync is on the pins
  // and the cycle after, when it is consumed. clr_at pulses i_cnt_clear
  // while symbol clr_at is driven (-1: never).
  task automatic send_frame(input logic [31:0] w, input bit sync_tag, input int clr_at);
    for (int i = 0; i < NSYM; i++) begin
      d       = w[31-2*i -: 2];
      sync_in = sync_tag && (i < 2);
      clr     = (i == clr_at);
      step();
    end
    sync_in = 1'b0;
    clr     = 1'b0;
  endtask

  function automatic logic [31:0] rand_frame();
    return {ISY, 14'($urandom), QSY, 14'($urandom)};
  endfunction

  task automatic idle_disabled(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) send_sym(2'b00);
    en = 1'b1;
  endtask

  int base_push, base_err, base_ovf;

  initial begin
    rst = 1'b1; en = 1'b0; sync_in = 1'b0; clr = 1'b0; full = 1'b0; d = '0;
    model_reset();
    repeat (3) step();
    chk("wclk_follows_clk", 32'(wclk), 32'd1);
    rst = 1'b0; en = 1'b1;
    repeat (3) send_sym(2'b00);

    // 1: back-to-back known frames, lock after four
    push_cyc.delete();
    repeat (6) send_frame(32'h8ABC4DEF, 1'b0, -1);
    send_sym(2'b00);
    chk("t1_push_count", 32'(push_cyc.size()), 32'd2);
    if (push_cyc.size() >= 2)
      chk("t1_push_gap", 32'(push_cyc[1] - push_cyc[0]), 32'd16);
    chk("t1_data", data, 32'h8ABC4DEF);
    chk("t1_locked", 32'(locked), 32'd1);

    // 2: Q-sync error drops lock, then relock
    base_push = npush;
    send_frame(32'h8ABC0DEF, 1'b0, -1);
    chk("t2_no_push", 32'(npush - base_push), 32'd0);
    chk("t2_err", 32'(err_cnt), 32'd1);
    chk("t2_unlocked", 32'(locked), 32'd0);
    idle_disabled(2);
    repeat (4) send_frame(rand_frame(), 1'b0, -1);
    send_sym(2'b00);
    chk("t2_relocked", 32'(locked), 32'd1);

    // 3: FIFO full at completion
    base_push = npush;
    send_frame(rand_frame(), 1'b0, -1);
    full = 1'b1;
    send_frame(rand_frame(), 1'b0, -1);
    full = 1'b0;
    send_frame(rand_frame(), 1'b0, -1);
    send_sym(2'b00);
    chk("t3_ovf", 32'(ovf_cnt), 32'd1);
    chk("t3_pushes", 32'(npush - base_push), 32'd2);

    // 4: sync tag on the middle frame only
    psync = '0;
    send_frame(rand_frame(), 1'b0, -1);
    send_frame(rand_frame(), 1'b1, -1);
    send_frame(rand_frame(), 1'b0, -1);
    send_sym(2'b00);
    chk("t4_sync_tags", 32'(psync[2:0]), 32'b010);

    // 5: enable dropped mid I-phase
    base_push = npush; base_err = err_cnt; base_ovf = ovf_cnt;
    begin
      logic [31:0] w;
      w = rand_frame();
      for (int i = 0; i < 5; i++) send_sym(w[31-2*i -: 2]);
    end
    en = 1'b0;
    send_sym(2'b00);
    chk("t5_state_idle", 32'(dbg), 32'd0);
    chk("t5_unlocked", 32'(locked), 32'd0);
    en = 1'b1;
    send_sym(2'b00);
    repeat (4) send_frame(rand_frame(), 1'b0, -1);
    send_sym(2'b00);
    chk("t5_no_push", 32'(npush - base_push), 32'd0);
    chk("t5_err_hold", 32'(err_cnt), 32'(base_err));
    chk("t5_ovf_hold", 32'(ovf_cnt), 32'(base_ovf));
    chk("t5_relocked", 32'(locked), 32'd1);

    // 6: saturation and clear-wins
    force dut.u_err_cnt.cnt_q = 16'hFFFF;
    #1;
    release dut.u_err_cnt.cnt_q;
    m_err = SATV;
    send_frame(32'h8ABC0DEF, 1'b0, -1);
    chk("t6_saturated", 32'(err_cnt), 32'hFFFF);
    idle_disabled(2);
    send_frame(32'h8ABC0DEF, 1'b0, 9);
    chk("t6_clear_wins", 32'(err_cnt), 32'd0);
    idle_disabled(2);

    // 7: reset in the middle of a frame
    send_frame(rand_frame(), 1'b0, -1);
    begin
      logic [31:0] w;
      w = rand_frame();
      for (int i = 0; i < 10; i++) send_sym(w[31-2*i -: 2]);
    end
    rst = 1'b1;
    send_sym(2'b00);
    chk("t7_rst_state", 32'(dbg), 32'd0);
    chk("t7_rst_data", data, 32'd0);
    rst = 1'b0;

    // 8: random frames, gaps and raw noise with random side inputs
    for (int n = 0; n < 40; n++) begin
      full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 4)) send_sym(2'b00);
      end
      send_frame(($urandom_range(0, 7) == 0) ? $urandom : rand_frame(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 3 : -1);
    end
    full = 1'b0;
    for (int n = 0; n < 300; n++) begin
      d       = 2'($urandom);
      en      = ($urandom_range(0, 15) != 0);
      full    = ($urandom_range(0, 3) == 0);
      sync_in = 1'($urandom);
      clr     = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
